// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath widths and the packed control-bundle layout
// used by the decode, execute and forwarding logic.
package core_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ALUOP_W = 4;
   localparam int unsigned CTRL_W  = 8;

   // Bit positions inside {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,Branch,Jump,Valid}
   localparam int unsigned CTRL_REGWRITE = 7;
   localparam int unsigned CTRL_MEMREAD  = 6;
   localparam int unsigned CTRL_MEMWRITE = 5;
   localparam int unsigned CTRL_MEMTOREG = 4;
   localparam int unsigned CTRL_ALUSRC   = 3;
   localparam int unsigned CTRL_BRANCH   = 2;
   localparam int unsigned CTRL_JUMP     = 1;
   localparam int unsigned CTRL_VALID    = 0;

   localparam logic [CTRL_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/wb_bypass_mux.sv
// Writeback-to-decode operand bypass: forwards WB data when the retiring write targets idx_i.
module wb_bypass_mux #(
   parameter int unsigned Width = core_pkg::XLEN
) (
   input  logic             reg_write_w_i,
   input  logic [4:0]       rd_w_i,
   input  logic [4:0]       idx_i,
   input  logic [Width-1:0] wd_w_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o
);

   logic hit;

   // x0 is hard-wired zero, so a write to it must never be forwarded
   assign hit    = reg_write_w_i & (rd_w_i != 5'd0) & (rd_w_i == idx_i);
   assign data_o = hit ? wd_w_i : data_i;

endmodule

// File: rtl/de_stage_reg.sv
// Decode->Execute pipeline register with load-use bubble insertion, flush, hold with
// writeback refresh, capture-time writeback bypass and a bubble counter.
module de_stage_reg #(
   parameter int unsigned XLEN    = core_pkg::XLEN,
   parameter int unsigned ALUOP_W = core_pkg::ALUOP_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XLEN-1:0]    PC_FD,
   input  logic [4:0]         RS1_FD,
   input  logic [4:0]         RS2_FD,
   input  logic [4:0]         RD_FD,
   input  logic [XLEN-1:0]    IMM_FD,
   input  logic [XLEN-1:0]    RD1_FD,
   input  logic [XLEN-1:0]    RD2_FD,
   input  logic [7:0]         CTRL_FD,
   input  logic [ALUOP_W-1:0] ALUOp_FD,
   input  logic               RegWrite_W,
   input  logic [4:0]         RD_W,
   input  logic [XLEN-1:0]    WD_W,
   input  logic               Flush_DE,
   input  logic               Hold_DE,
   output logic [XLEN-1:0]    PC_DE,
   output logic [4:0]         RS1_DE,
   output logic [4:0]         RS2_DE,
   output logic [4:0]         RD_DE,
   output logic [XLEN-1:0]    IMM_DE,
   output logic [XLEN-1:0]    RD1_DE,
   output logic [XLEN-1:0]    RD2_DE,
   output logic [ALUOP_W-1:0] ALUOp_DE,
   output logic               RegWrite_DE,
   output logic               MemRead_DE,
   output logic               MemWrite_DE,
   output logic               MemToReg_DE,
   output logic               ALUSrc_DE,
   output logic               Branch_DE,
   output logic               Jump_DE,
   output logic               Valid_DE,
   output logic               Stall_FD,
   output logic [31:0]        BubbleCount
);

   import core_pkg::*;

   logic [XLEN-1:0]    pc_q, pc_d, imm_q, imm_d, rd1_q, rd1_d, rd2_q, rd2_d;
   logic [4:0]         rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [7:0]         ctrl_q, ctrl_d;
   logic [ALUOP_W-1:0] aluop_q, aluop_d;
   logic [31:0]        bubble_cnt_q, bubble_cnt_d;

   logic            load_use;
   logic [4:0]      byp1_idx, byp2_idx;
   logic [XLEN-1:0] byp1_in, byp2_in, byp1_out, byp2_out;

   assign load_use = ctrl_q[CTRL_MEMREAD] & ctrl_q[CTRL_VALID] & (rd_q != 5'd0) &
                     ((rd_q == RS1_FD) | (rd_q == RS2_FD));
   assign Stall_FD = ~rst & (load_use | Hold_DE);

   // One mux pair serves both uses: refresh of held operands, or bypass of incoming ones
   assign byp1_idx = Hold_DE ? rs1_q : RS1_FD;
   assign byp1_in  = Hold_DE ? rd1_q : RD1_FD;
   assign byp2_idx = Hold_DE ? rs2_q : RS2_FD;
   assign byp2_in  = Hold_DE ? rd2_q : RD2_FD;

   wb_bypass_mux #(.Width(XLEN)) u_byp_rs1 (
      .reg_write_w_i (RegWrite_W),
      .rd_w_i        (RD_W),
      .idx_i         (byp1_idx),
      .wd_w_i        (WD_W),
      .data_i        (byp1_in),
      .data_o        (byp1_out)
   );

   wb_bypass_mux #(.Width(XLEN)) u_byp_rs2 (
      .reg_write_w_i (RegWrite_W),
      .rd_w_i        (RD_W),
      .idx_i         (byp2_idx),
      .wd_w_i        (WD_W),
      .data_i        (byp2_in),
      .data_o        (byp2_out)
   );

   always_comb begin
      pc_d         = pc_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rd_d         = rd_q;
      imm_d        = imm_q;
      rd1_d        = rd1_q;
      rd2_d        = rd2_q;
      ctrl_d       = ctrl_q;
      aluop_d      = aluop_q;
      bubble_cnt_d = bubble_cnt_q;
      if (Flush_DE || (!Hold_DE && load_use)) begin
         pc_d    = '0;
         rs1_d   = '0;
         rs2_d   = '0;
         rd_d    = '0;
         imm_d   = '0;
         rd1_d   = '0;
         rd2_d   = '0;
         ctrl_d  = BUBBLE;
         aluop_d = '0;
         if (!Flush_DE) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
         end
      end else if (Hold_DE) begin
         rd1_d = byp1_out;
         rd2_d = byp2_out;
      end else begin
         pc_d    = PC_FD;
         rs1_d   = RS1_FD;
         rs2_d   = RS2_FD;
         rd_d    = RD_FD;
         imm_d   = IMM_FD;
         rd1_d   = byp1_out;
         rd2_d   = byp2_out;
         ctrl_d  = CTRL_FD;
         aluop_d = ALUOp_FD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         imm_q        <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         ctrl_q       <= BUBBLE;
         aluop_q      <= '0;
         bubble_cnt_q <= '0;
      end else begin
         pc_q         <= pc_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         imm_q        <= imm_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         ctrl_q       <= ctrl_d;
         aluop_q      <= aluop_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign PC_DE       = pc_q;
   assign RS1_DE      = rs1_q;
   assign RS2_DE      = rs2_q;
   assign RD_DE       = rd_q;
   assign IMM_DE      = imm_q;
   assign RD1_DE      = rd1_q;
   assign RD2_DE      = rd2_q;
   assign ALUOp_DE    = aluop_q;
   assign RegWrite_DE = ctrl_q[CTRL_REGWRITE];
   assign MemRead_DE  = ctrl_q[CTRL_MEMREAD];
   assign MemWrite_DE = ctrl_q[CTRL_MEMWRITE];
   assign MemToReg_DE = ctrl_q[CTRL_MEMTOREG];
   assign ALUSrc_DE   = ctrl_q[CTRL_ALUSRC];
   assign Branch_DE   = ctrl_q[CTRL_BRANCH];
   assign Jump_DE     = ctrl_q[CTRL_JUMP];
   assign Valid_DE    = ctrl_q[CTRL_VALID];
   assign BubbleCount = bubble_cnt_q;

endmodule
